mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one downstream memory port between the instruction-fetch requester and the memory-access (load/store) requester of the multi-cycle RISC-V pipeline. It accepts one transaction at a time, registers its address, write data and strobe on grant, and issues it downstream. Read responses are routed back to the owning requester, and write completion is signalled at request acceptance. It sits between the pipeline stages and the memory/cache interface, in place of the two separate request/response channels.

## Interface
- No parameters. Address and data widths are fixed at 32 bits.
- `clk` — in — 1 — system clock.
- `rst` — in — 1 — asynchronous, active-low reset.
- `I_Addr` — in — 32 — instruction fetch address.
- `I_Req_Valid` — in — 1 — fetch request.
- `I_Req_Ready` — out — 1 — fetch request accepted.
- `I_Rdata` — out — 32 — instruction returned.
- `I_Rvalid` — out — 1 — instruction valid.
- `I_Rready` — in — 1 — fetch side ready for instruction.
- `D_Addr` — in — 32 — data address.
- `D_Read` — in — 1 — load request.
- `D_Write` — in — 1 — store request.
- `D_Wdata` — in — 32 — store data.
- `D_Wstrb` — in — 4 — store byte strobes.
- `D_Req_Ready` — out — 1 — data request accepted.
- `D_Rdata` — out — 32 — load data.
- `D_Rvalid` — out — 1 — load data valid.
- `D_Rready` — in — 1 — MA side ready for load data.
- `M_Addr` — out — 32 — downstream address.
- `M_Wen` — out — 1 — downstream write (1) or read (0).
- `M_Wdata` — out — 32 — downstream store data.
- `M_Wstrb` — out — 4 — downstream strobes.
- `M_Req_Valid` — out — 1 — downstream request.
- `M_Req_Ready` — in — 1 — downstream accepted.
- `M_Rdata` — in — 32 — downstream read data.
- `M_Rvalid` — in — 1 — downstream read data valid.
- `M_Rready` — out — 1 — arbiter ready for read data.

## Operation
- The FSM is one-hot with three states: IDLE, REQ and RESP. The owner register `own` is I or D.
- IDLE:
  - A requester is a candidate when `I_Req_Valid` is high, or when `D_Read | D_Write` is high.
  - If any candidate exists, the grant goes to the pick. Address, write enable, write data and strobe are latched into internal registers, `own` is set, and the FSM moves to REQ.
  - If `D_Read` and `D_Write` are both high, it is a write.
- REQ:
  - `M_Req_Valid` = 1 and `M_*` are driven from the latched registers.
  - The owner's `*_Req_Ready` equals `M_Req_Ready` combinationally. The non-owner's ready is 0.
  - On `M_Req_Ready`: a write returns to IDLE, and a read goes to RESP.
- RESP:
  - `M_Rready` = the owner's `*_Rready`.
  - The owner's `*_Rvalid` = `M_Rvalid`, and `*_Rdata` = `M_Rdata`. The non-owner's Rvalid is 0.
  - When `M_Rvalid & M_Rready`, the FSM returns to IDLE.
- Requesters hold valid and payload stable until ready. Payload changes after the grant are ignored.
- The instruction side never issues writes; `I_*` grants always have `M_Wen` = 0 and `M_Wstrb` = 0.
- Pick (default): fixed priority, D over I. The MA stage stalls the whole pipeline, so it must not be starved.

## Timing
- Reset (`rst` = 0, asynchronous): the FSM goes to IDLE, `own` = I, and all outputs are 0. The `M_Addr`, `M_Wdata` and `M_Wstrb` registers are cleared to 0.
- A reset asserted mid-transaction abandons the transaction. No response is forwarded after reset is released.
- Request seen at cycle T: `M_Req_Valid` rises at T+1. Upstream ready coincides with `M_Req_Ready`, earliest at T+1.
- Read data from downstream passes through combinationally (0 cycles) in RESP. The earliest IDLE after a read is T+3.
- A store completes at T+1 at the earliest. A new grant can be issued in the cycle after returning to IDLE, so there is no back-to-back issue.
- Simultaneous `I_Req_Valid` and `D_Read` in IDLE: D is granted and I waits. I is granted on the next IDLE if it is still valid.
- `M_Rvalid` outside RESP is ignored, and `M_Rready` = 0 outside RESP.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin pick. A 1-bit `last` register holds the owner of the most recent grant. On contention the other requester wins; with no contention the sole requester wins. `last` resets to I, so D wins the first contention.
- `ARB_ROUND_ROBIN_EN` undefined: fixed D-over-I priority, and the `last` register is not present.

## Structure
- Package `mem_arb_pkg`:
  - state encoding localparams `S_IDLE`, `S_REQ`, `S_RESP`;
  - owner constants `OWN_I`, `OWN_D`.
- Sub-module `arb_pick`: combinational winner selection from the two valid flags and `last`. The macro is resolved inside this sub-module only.
- The FSM, payload registers and response routing stay in `mem_port_arbiter`.

## Test plan
- Lone fetch: `I_Addr` = 0x100, `M_Req_Ready` = 1, `M_Rdata` = 0x00000013 after 2 cycles. Expect `M_Wen` = 0, `I_Rvalid` pulse with `I_Rdata` = 0x13, and `D_Rvalid` stays 0.
- Store: `D_Write`, `D_Addr` = 0x2004, `D_Wdata` = 0xAABB0000, `D_Wstrb` = 0xC. Expect `M_Wen` = 1, `M_Wstrb` = 0xC, and `D_Req_Ready` in the same cycle as `M_Req_Ready`. Expect return to IDLE with no RESP visit.
- Contention (fixed priority): `I_Req_Valid` and `D_Read` rise in the same cycle. Expect D's address 0x3000 issued first and I's 0x104 issued after D's read completes.
- Contention with `ARB_ROUND_ROBIN_EN`: a continuous `I_Req_Valid` and `D_Read` stream gives an issue order of D, I, D, I.
- Backpressure: `M_Req_Ready` held 0 for 5 cycles, then `D_Rready` held 0 for 3 cycles while `M_Rvalid` = 1. Expect `M_Req_Valid` and `M_Addr` stable, `M_Rready` = 0, and no premature return to IDLE.
- Reset in RESP: `rst` driven 0 while awaiting read data. Expect all outputs 0 immediately. After release, a late `M_Rvalid` produces no `I_Rvalid` or `D_Rvalid`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: one-hot FSM states, owner
// constants and the latched downstream request record.
package mem_arb_pkg;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_REQ  = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_RESP = S_RESP
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and downstream memory channels.
// master: arbiter view; slave: the environment (pipeline + memory) view.
interface mem_port_arbiter_if;

  logic [31:0] I_Addr;
  logic        I_Req_Valid;
  logic        I_Req_Ready;
  logic [31:0] I_Rdata;
  logic        I_Rvalid;
  logic        I_Rready;

  logic [31:0] D_Addr;
  logic        D_Read;
  logic        D_Write;
  logic [31:0] D_Wdata;
  logic [3:0]  D_Wstrb;
  logic        D_Req_Ready;
  logic [31:0] D_Rdata;
  logic        D_Rvalid;
  logic        D_Rready;

  logic [31:0] M_Addr;
  logic        M_Wen;
  logic [31:0] M_Wdata;
  logic [3:0]  M_Wstrb;
  logic        M_Req_Valid;
  logic        M_Req_Ready;
  logic [31:0] M_Rdata;
  logic        M_Rvalid;
  logic        M_Rready;

  modport master (
    input  I_Addr, I_Req_Valid, I_Rready,
    input  D_Addr, D_Read, D_Write, D_Wdata, D_Wstrb, D_Rready,
    input  M_Req_Ready, M_Rdata, M_Rvalid,
    output I_Req_Ready, I_Rdata, I_Rvalid,
    output D_Req_Ready, D_Rdata, D_Rvalid,
    output M_Addr, M_Wen, M_Wdata, M_Wstrb, M_Req_Valid, M_Rready
  );

  modport slave (
    output I_Addr, I_Req_Valid, I_Rready,
    output D_Addr, D_Read, D_Write, D_Wdata, D_Wstrb, D_Rready,
    output M_Req_Ready, M_Rdata, M_Rvalid,
    input  I_Req_Ready, I_Rdata, I_Rvalid,
    input  D_Req_Ready, D_Rdata, D_Rvalid,
    input  M_Addr, M_Wen, M_Wdata, M_Wstrb, M_Req_Valid, M_Rready
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner selection between fetch and load/store requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise D beats I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_vld,
  input  logic d_vld,
  input  logic last,
  output logic any_vld,
  output logic pick
);

  assign any_vld = i_vld | d_vld;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    pick = d_vld ? OWN_D : OWN_I;
    if (i_vld && d_vld) begin
      pick = (last == OWN_I) ? OWN_D : OWN_I;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign pick = d_vld ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and load/store.
// Pick policy is set in arb_pick by ARB_ROUND_ROBIN_EN (default: D over I).
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  state_t   state_q, state_d;
  logic     own_q, own_d;
  logic     last_q, last_d;
  mem_req_t req_q, req_d;

  logic d_vld;
  logic any_vld;
  logic pick;
  logic in_req;
  logic in_resp;
  logic own_is_d;
  logic m_rready;

  assign d_vld = bus.D_Read | bus.D_Write;

  arb_pick u_pick (
    .i_vld   (bus.I_Req_Valid),
    .d_vld   (d_vld),
    .last    (last_q),
    .any_vld (any_vld),
    .pick    (pick)
  );

  assign in_req   = (state_q == ST_REQ);
  assign in_resp  = (state_q == ST_RESP);
  assign own_is_d = (own_q == OWN_D);
  assign m_rready = in_resp & (own_is_d ? bus.D_Rready : bus.I_Rready);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_vld) begin
          own_d   = pick;
          last_d  = pick;
          state_d = ST_REQ;
          // A simultaneous read+write from MA is treated as a write.
          if (pick == OWN_D) begin
            req_d.addr  = bus.D_Addr;
            req_d.wen   = bus.D_Write;
            req_d.wdata = bus.D_Write ? bus.D_Wdata : 32'h0;
            req_d.wstrb = bus.D_Write ? bus.D_Wstrb : 4'h0;
          end else begin
            req_d.addr  = bus.I_Addr;
            req_d.wen   = 1'b0;
            req_d.wdata = 32'h0;
            req_d.wstrb = 4'h0;
          end
        end
      end
      ST_REQ: begin
        if (bus.M_Req_Ready) begin
          state_d = req_q.wen ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.M_Rvalid && m_rready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_I;
      last_q  <= OWN_I;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      req_q   <= req_d;
    end
  end

  // Request ready and read data are steered to the owner only; the other side sees 0.
  assign bus.M_Req_Valid = in_req;
  assign bus.M_Addr      = req_q.addr;
  assign bus.M_Wen       = req_q.wen;
  assign bus.M_Wdata     = req_q.wdata;
  assign bus.M_Wstrb     = req_q.wstrb;
  assign bus.M_Rready    = m_rready;

  assign bus.I_Req_Ready = in_req & ~own_is_d & bus.M_Req_Ready;
  assign bus.D_Req_Ready = in_req &  own_is_d & bus.M_Req_Ready;

  assign bus.I_Rvalid = in_resp & ~own_is_d & bus.M_Rvalid;
  assign bus.D_Rvalid = in_resp &  own_is_d & bus.M_Rvalid;
  assign bus.I_Rdata  = (in_resp & ~own_is_d) ? bus.M_Rdata : 32'h0;
  assign bus.D_Rdata  = (in_resp &  own_is_d) ? bus.M_Rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// issues/responses; a negedge monitor pops and compares on each handshake.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        side;
  } iss_t;

  typedef struct {
    logic        side;
    logic [31:0] data;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  iss_t mon_e;
  rsp_t mon_r;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat_a;
  int   lat_s;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur within bound", nm);
  endtask

  function automatic logic [159:0] all_outs();
    return {bus.I_Req_Ready, bus.I_Rdata, bus.I_Rvalid,
            bus.D_Req_Ready, bus.D_Rdata, bus.D_Rvalid,
            bus.M_Addr, bus.M_Wen, bus.M_Wdata, bus.M_Wstrb,
            bus.M_Req_Valid, bus.M_Rready};
  endfunction

  // Monitor: compares each downstream issue and each read-data transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.M_Req_Valid && bus.M_Req_Ready) begin
        if (exp_iss.size() == 0) begin
          fail_now("unexpected_issue");
        end else begin
          mon_e = exp_iss.pop_front();
          check("issue", {bus.M_Addr, bus.M_Wen, bus.M_Wdata, bus.M_Wstrb,
                          bus.I_Req_Ready, bus.D_Req_Ready},
                {mon_e.addr, mon_e.wen, mon_e.wdata, mon_e.wstrb,
                 mon_e.side == OWN_I, mon_e.side == OWN_D});
        end
      end
      if (bus.M_Rvalid && bus.M_Rready) begin
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          mon_r = exp_rsp.pop_front();
          check("response", {bus.I_Rvalid, bus.D_Rvalid,
                             (mon_r.side == OWN_D) ? bus.D_Rdata : bus.I_Rdata},
                {mon_r.side == OWN_I, mon_r.side == OWN_D, mon_r.data});
        end
      end else if (bus.M_Rvalid && exp_rsp.size() == 0) begin
        check("stray_rvalid", {bus.I_Rvalid, bus.D_Rvalid}, 2'b00);
      end
    end
  end

  task automatic req_i(input logic [31:0] base, input int n);
    bit hs;
    int cnt;
    for (int k = 0; k < n; k++) begin
      bus.I_Addr      = base + 32'(4 * k);
      bus.I_Req_Valid = 1'b1;
      hs = 1'b0;
      cnt = 0;
      while (!hs && cnt < 100) begin
        @(negedge clk);
        hs = bus.I_Req_Ready;
        @(posedge clk); #1;
        cnt++;
      end
      if (!hs) fail_now("i_req_ready");
    end
    bus.I_Req_Valid = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] base, input int n, input bit wr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bit hs;
    int cnt;
    for (int k = 0; k < n; k++) begin
      bus.D_Addr  = base + 32'(4 * k);
      bus.D_Read  = !wr;
      bus.D_Write = wr;
      bus.D_Wdata = wdata;
      bus.D_Wstrb = wstrb;
      hs = 1'b0;
      cnt = 0;
      while (!hs && cnt < 100) begin
        @(negedge clk);
        hs = bus.D_Req_Ready;
        @(posedge clk); #1;
        cnt++;
      end
      if (!hs) fail_now("d_req_ready");
    end
    bus.D_Read  = 1'b0;
    bus.D_Write = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit seen, output bit wr,
                            output logic [31:0] addr);
    lat = 0;
    seen = 1'b0;
    wr = 1'b0;
    addr = '0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      seen = bus.M_Req_Valid;
      wr   = bus.M_Wen;
      addr = bus.M_Addr;
      @(posedge clk); #1;
      if (!seen) lat++;
    end
    if (!seen) fail_now("m_req_valid");
  endtask

  // Downstream memory model; from_addr derives read data from the issued address.
  task automatic serve(input int stall, input logic [31:0] rdata, input bit from_addr,
                       input int rv_delay, output int lat);
    bit seen;
    bit wr;
    bit hs;
    int cnt;
    logic [31:0] a;
    bus.M_Req_Ready = (stall == 0);
    wait_valid(lat, seen, wr, a);
    if (seen) begin
      if (stall > 0) begin
        repeat (stall - 1) begin @(posedge clk); #1; end
        bus.M_Req_Ready = 1'b1;
        @(posedge clk); #1;
      end
      bus.M_Req_Ready = 1'b0;
      if (!wr) begin
        repeat (rv_delay) begin @(posedge clk); #1; end
        bus.M_Rdata  = from_addr ? (a ^ 32'hA5A5_0000) : rdata;
        bus.M_Rvalid = 1'b1;
        hs = 1'b0;
        cnt = 0;
        while (!hs && cnt < 60) begin
          @(negedge clk);
          hs = bus.M_Rready;
          @(posedge clk); #1;
          cnt++;
        end
        if (!hs) fail_now("m_rready");
        bus.M_Rvalid = 1'b0;
        bus.M_Rdata  = '0;
      end
    end
    bus.M_Req_Ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_r;
    bit wr_r;
    logic [31:0] a_r;
    bus.I_Addr = '0;  bus.I_Req_Valid = 1'b0; bus.I_Rready = 1'b1;
    bus.D_Addr = '0;  bus.D_Read = 1'b0; bus.D_Write = 1'b0;
    bus.D_Wdata = '0; bus.D_Wstrb = '0; bus.D_Rready = 1'b1;
    bus.M_Req_Ready = 1'b0; bus.M_Rdata = '0; bus.M_Rvalid = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), '0);
    @(posedge clk); #1;

    // Lone fetch
    exp_iss.push_back('{32'h100, 1'b0, 32'h0, 4'h0, OWN_I});
    exp_rsp.push_back('{OWN_I, 32'h0000_0013});
    fork
      req_i(32'h100, 1);
      serve(0, 32'h0000_0013, 1'b0, 2, lat_a);
    join
    check("fetch_issue_latency", lat_a, 1);

    // Contention: D wins first, I follows
    exp_iss.push_back('{32'h3000, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_iss.push_back('{32'h104, 1'b0, 32'h0, 4'h0, OWN_I});
    exp_rsp.push_back('{OWN_D, 32'hDEAD_0001});
    exp_rsp.push_back('{OWN_I, 32'h0000_0093});
    fork
      req_i(32'h104, 1);
      req_d(32'h3000, 1, 1'b0, 32'h0, 4'h0);
      begin
        serve(0, 32'hDEAD_0001, 1'b0, 0, lat_s);
        serve(0, 32'h0000_0093, 1'b0, 1, lat_s);
      end
    join

    // Continuous contention stream
`ifdef ARB_ROUND_ROBIN_EN
    exp_iss.push_back('{32'h5000, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_iss.push_back('{32'h180,  1'b0, 32'h0, 4'h0, OWN_I});
    exp_iss.push_back('{32'h5004, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_iss.push_back('{32'h184,  1'b0, 32'h0, 4'h0, OWN_I});
    exp_rsp.push_back('{OWN_D, 32'hA5A5_5000});
    exp_rsp.push_back('{OWN_I, 32'hA5A5_0180});
    exp_rsp.push_back('{OWN_D, 32'hA5A5_5004});
    exp_rsp.push_back('{OWN_I, 32'hA5A5_0184});
`else
    exp_iss.push_back('{32'h5000, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_iss.push_back('{32'h5004, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_iss.push_back('{32'h180,  1'b0, 32'h0, 4'h0, OWN_I});
    exp_iss.push_back('{32'h184,  1'b0, 32'h0, 4'h0, OWN_I});
    exp_rsp.push_back('{OWN_D, 32'hA5A5_5000});
    exp_rsp.push_back('{OWN_D, 32'hA5A5_5004});
    exp_rsp.push_back('{OWN_I, 32'hA5A5_0180});
    exp_rsp.push_back('{OWN_I, 32'hA5A5_0184});
`endif
    fork
      req_d(32'h5000, 2, 1'b0, 32'h0, 4'h0);
      req_i(32'h180, 2);
      begin
        for (int k = 0; k < 4; k++) serve(0, 32'h0, 1'b1, 0, lat_s);
      end
    join

    // Store: completes at request acceptance, no RESP visit
    exp_iss.push_back('{32'h2004, 1'b1, 32'hAABB_0000, 4'hC, OWN_D});
    fork
      req_d(32'h2004, 1, 1'b1, 32'hAABB_0000, 4'hC);
      serve(0, 32'h0, 1'b0, 0, lat_a);
    join
    check("store_issue_latency", lat_a, 1);
    @(negedge clk);
    check("store_back_to_idle", {bus.M_Req_Valid, bus.M_Rready, bus.D_Rvalid}, 3'b000);
    @(posedge clk); #1;

    // Backpressure on request and on read data
    exp_iss.push_back('{32'h4000, 1'b0, 32'h0, 4'h0, OWN_D});
    exp_rsp.push_back('{OWN_D, 32'h0BAD_F00D});
    fork
      req_d(32'h4000, 1, 1'b0, 32'h0, 4'h0);
      begin
        bus.M_Req_Ready = 1'b0;
        wait_valid(lat_s, seen_r, wr_r, a_r);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_req_hold", {bus.M_Req_Valid, bus.M_Addr, bus.D_Req_Ready},
                {1'b1, 32'h4000, 1'b0});
          @(posedge clk); #1;
        end
        bus.M_Req_Ready = 1'b1;
        @(posedge clk); #1;
        bus.M_Req_Ready = 1'b0;
        bus.D_Rready = 1'b0;
        bus.M_Rvalid = 1'b1;
        bus.M_Rdata  = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_rready_hold", {bus.M_Rready, bus.D_Rvalid, bus.D_Rdata, bus.M_Req_Valid},
                {1'b0, 1'b1, 32'h0BAD_F00D, 1'b0});
          @(posedge clk); #1;
        end
        bus.D_Rready = 1'b1;
        @(posedge clk); #1;
        bus.M_Rvalid = 1'b0;
        bus.M_Rdata  = '0;
      end
    join

    // Reset while awaiting read data
    exp_iss.push_back('{32'h200, 1'b0, 32'h0, 4'h0, OWN_I});
    bus.M_Req_Ready = 1'b1;
    fork
      req_i(32'h200, 1);
      wait_valid(lat_s, seen_r, wr_r, a_r);
    join
    bus.M_Req_Ready = 1'b0;
    @(negedge clk);
    check("resp_wait", {bus.M_Rready, bus.I_Rvalid, bus.M_Addr}, {1'b1, 1'b0, 32'h200});
    #2 rst = 1'b0;
    #1 check("reset_async_outputs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.M_Rvalid = 1'b1;
    bus.M_Rdata  = 32'hBAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_rvalid_dropped", {bus.I_Rvalid, bus.D_Rvalid, bus.M_Rready}, 3'b000);
      @(posedge clk); #1;
    end
    bus.M_Rvalid = 1'b0;

    check("issue_queue_drained", exp_iss.size(), 0);
    check("response_queue_drained", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
